// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan and bit-plane sequencer: walks rows and colour planes, hands each row shift
// to hub75_color_tx and drives row address and OE for binary-code-modulated on-times.
module hub75_scan_ctrl #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_enable,
  input  logic [7:0]                             i_base_cnt,
  input  logic [7:0]                             i_blank_cnt,
  input  logic                                   i_tx_ready,
  output logic                                   o_tx_start,
  output logic [$clog2(hpixel_p*vpixel_p)-1:0]   o_tx_init_addr,
  output logic [$clog2(bpp_p)-1:0]               o_tx_pix_bit,
  output logic [$clog2(vpixel_p/segments_p)-1:0] o_row_addr,
  output logic                                   o_oe_n,
  output logic                                   o_frame_done,
  output logic                                   o_busy
);
  localparam int rows_p          = vpixel_p / segments_p;
  localparam int row_width_p     = $clog2(rows_p);
  localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p);
  localparam int pix_bit_width_p = $clog2(bpp_p);
  localparam int on_width_p      = 8 + bpp_p;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, SHOW, BLANK} state_t;

  state_t                     state;
  logic [7:0]                 base_r;
  logic [7:0]                 blank_r;
  logic [7:0]                 blank_cnt;
  logic [on_width_p-1:0]      on_cnt;
  logic [row_width_p-1:0]     row;
  logic [pix_bit_width_p-1:0] plane;
  logic                       oe_r;
  logic [row_width_p-1:0]     row_nxt;
  logic [pix_bit_width_p-1:0] plane_nxt;

  assign row_nxt   = row + row_width_p'(1);
  assign plane_nxt = plane + pix_bit_width_p'(1);

  // A zero count would collapse a phase entirely, so it is stretched to one cycle.
  function automatic logic [7:0] at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  function automatic logic [addr_width_p-1:0] row_base(input logic [row_width_p-1:0] r);
    return addr_width_p'(r) * addr_width_p'(hpixel_p);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      row            <= '0;
      plane          <= '0;
      o_tx_start     <= 1'b0;
      o_tx_init_addr <= '0;
      o_tx_pix_bit   <= '0;
      o_row_addr     <= '0;
      oe_r           <= 1'b1;
      o_frame_done   <= 1'b0;
    end else begin
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          oe_r <= 1'b1;
          if (i_enable) begin
            base_r         <= at_least_one(i_base_cnt);
            blank_r        <= at_least_one(i_blank_cnt);
            row            <= '0;
            plane          <= '0;
            o_tx_init_addr <= '0;
            o_tx_pix_bit   <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_tx_ready) begin
            o_tx_start <= 1'b1;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!i_tx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Row lines move only here, while the panel is still dark.
          if (i_tx_ready) begin
            o_row_addr <= row;
            on_cnt     <= on_width_p'(base_r) << plane;
            oe_r       <= 1'b0;
            state      <= SHOW;
          end
        end
        SHOW: begin
          if (on_cnt <= on_width_p'(1)) begin
            oe_r      <= 1'b1;
            blank_cnt <= blank_r;
            state     <= BLANK;
          end else begin
            on_cnt <= on_cnt - on_width_p'(1);
          end
        end
        BLANK: begin
          if (blank_cnt > 8'd1) begin
            blank_cnt <= blank_cnt - 8'd1;
          end else if (plane != pix_bit_width_p'(bpp_p - 1)) begin
            plane          <= plane_nxt;
            o_tx_pix_bit   <= plane_nxt;
            o_tx_init_addr <= row_base(row);
            state          <= ISSUE;
          end else if (row != row_width_p'(rows_p - 1)) begin
            row            <= row_nxt;
            plane          <= '0;
            o_tx_pix_bit   <= '0;
            o_tx_init_addr <= row_base(row_nxt);
            state          <= ISSUE;
          end else begin
            o_frame_done <= 1'b1;
            if (i_enable) begin
              base_r         <= at_least_one(i_base_cnt);
              blank_r        <= at_least_one(i_blank_cnt);
              row            <= '0;
              plane          <= '0;
              o_tx_init_addr <= '0;
              o_tx_pix_bit   <= '0;
              state          <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset blanks the panel combinationally so it never waits for an edge.
  assign o_oe_n = oe_r | rst;
  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed/randomized bench for hub75_scan_ctrl with a handshake-level tx model and
// a frame-level reference of the expected start sequence and BCM on-times.
module tb_hub75_scan_ctrl;
  localparam int H = 64;
  localparam int ROWS = 32;
  localparam int PLANES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [7:0]  i_base_cnt = 8'd2;
  logic [7:0]  i_blank_cnt = 8'd1;
  logic        tx_m = 1'b1;
  logic        tx_hold = 1'b0;
  logic        i_tx_ready;
  logic        o_tx_start;
  logic [11:0] o_tx_init_addr;
  logic [2:0]  o_tx_pix_bit;
  logic [4:0]  o_row_addr;
  logic        o_oe_n;
  logic        o_frame_done;
  logic        o_busy;

  assign i_tx_ready = tx_m & ~tx_hold;

  hub75_scan_ctrl dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_base_cnt(i_base_cnt),
    .i_blank_cnt(i_blank_cnt), .i_tx_ready(i_tx_ready), .o_tx_start(o_tx_start),
    .o_tx_init_addr(o_tx_init_addr), .o_tx_pix_bit(o_tx_pix_bit),
    .o_row_addr(o_row_addr), .o_oe_n(o_oe_n), .o_frame_done(o_frame_done),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int tx_lat = 10;
  bit tx_rand = 1'b0;

  int unsigned st_addr_q[$];
  int unsigned st_bit_q[$];
  int unsigned on_len_q[$];
  int unsigned on_row_q[$];
  int fd_cnt = 0;
  int viol = 0;
  int cyc = 0;
  int run = 0;
  int last_rise = 0;
  int fd_gap = 0;

  // tx stand-in: drops ready after a start, raises it again once shift+latch is done
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start === 1'b1) begin
        tx_m = 1'b0;
        repeat (tx_rand ? $urandom_range(2, 8) : tx_lat) @(negedge clk);
        tx_m = 1'b1;
      end
    end
  end

  // Observer: logs starts, OE-low runs with their row, frame_done spacing
  initial begin
    logic       prev_oe;
    logic [4:0] prev_row;
    prev_oe = 1'b1;
    prev_row = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_tx_start === 1'b1) begin
        st_addr_q.push_back(int'(o_tx_init_addr));
        st_bit_q.push_back(int'(o_tx_pix_bit));
      end
      if (o_oe_n === 1'b0) begin
        if (prev_oe === 1'b0 && o_row_addr !== prev_row) viol++;
        run++;
      end else if (prev_oe === 1'b0) begin
        on_len_q.push_back(run);
        on_row_q.push_back(int'(prev_row));
        run = 0;
        last_rise = cyc;
      end
      if (o_frame_done === 1'b1) begin
        fd_cnt++;
        fd_gap = cyc - last_rise;
      end
      prev_oe = o_oe_n;
      prev_row = o_row_addr;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int fd0, input int limit);
    int n = 0;
    while (fd_cnt == fd0 && n < limit) begin
      tick(1);
      n++;
    end
    check("frame_done_seen", 32'(fd_cnt != fd0), 32'd1);
  endtask

  // Reference: rows 0..31, planes LSB first, on-time = max(base,1) * 2^plane.
  task automatic verify_frame(input int s0, input int o0, input int base_eff,
                              input int blank_eff, input int fd0, input string tag);
    int bad_s = 0;
    int bad_o = 0;
    int bad_r = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int b = 0; b < PLANES; b++) begin
        int si = s0 + r * PLANES + b;
        int oi = o0 + r * PLANES + b;
        if (si >= st_addr_q.size() || st_addr_q[si] != r * H || st_bit_q[si] != b) bad_s++;
        if (oi >= on_len_q.size() || on_len_q[oi] != base_eff * (1 << b)) bad_o++;
        if (oi >= on_row_q.size() || on_row_q[oi] != r) bad_r++;
      end
    end
    check({tag, "_start_count"}, 32'(st_addr_q.size() - s0), 32'(ROWS * PLANES));
    check({tag, "_start_seq_errs"}, 32'(bad_s), 32'd0);
    check({tag, "_on_time_errs"}, 32'(bad_o), 32'd0);
    check({tag, "_row_addr_errs"}, 32'(bad_r), 32'd0);
    check({tag, "_frame_done_pulses"}, 32'(fd_cnt - fd0), 32'd1);
    check({tag, "_last_blank_len"}, 32'(fd_gap), 32'(blank_eff));
  endtask

  initial begin
    int s0, o0, fd0, n, blank_c;

    // Reset and idle
    tick(3);
    rst = 1'b0;
    tick(20);
    check("idle_oe_n", 32'(o_oe_n), 32'd1);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_starts", 32'(st_addr_q.size()), 32'd0);
    check("idle_row_addr", 32'(o_row_addr), 32'd0);
    check("idle_init_addr", 32'(o_tx_init_addr), 32'd0);
    check("idle_pix_bit", 32'(o_tx_pix_bit), 32'd0);
    check("idle_frame_done", 32'(fd_cnt), 32'd0);
    check("idle_tx_start", 32'(o_tx_start), 32'd0);

    // Frame A: base=2, blank=1, fixed tx latency of 10
    s0 = st_addr_q.size(); o0 = on_len_q.size(); fd0 = fd_cnt;
    i_base_cnt = 8'd2; i_blank_cnt = 8'd1; i_enable = 1'b1;
    tick(3);
    check("a_busy", 32'(o_busy), 32'd1);
    i_enable = 1'b0;
    wait_frame(fd0, 40000);
    tick(5);
    check("a_first_addr", st_addr_q[s0], 32'd0);
    check("a_first_bit", st_bit_q[s0], 32'd0);
    check("a_row5_addr", st_addr_q[s0 + 5 * PLANES], 32'd320);
    check("a_on_bit0", on_len_q[o0], 32'd2);
    check("a_on_bit7", on_len_q[o0 + 7], 32'd256);
    verify_frame(s0, o0, 2, 1, fd0, "a");
    check("a_row_change_while_lit", 32'(viol), 32'd0);
    check("a_end_busy", 32'(o_busy), 32'd0);
    check("a_end_oe_n", 32'(o_oe_n), 32'd1);

    // Frame B: zero counts behave as one; randomized tx latency
    tx_rand = 1'b1;
    s0 = st_addr_q.size(); o0 = on_len_q.size(); fd0 = fd_cnt;
    i_base_cnt = 8'd0; i_blank_cnt = 8'd0; i_enable = 1'b1;
    tick(3);
    i_enable = 1'b0;
    wait_frame(fd0, 40000);
    tick(5);
    check("b_on_bit0", on_len_q[o0], 32'd1);
    verify_frame(s0, o0, 1, 1, fd0, "b");

    // Frame C: enable dropped and base changed during row 10
    blank_c = $urandom_range(0, 4);
    s0 = st_addr_q.size(); o0 = on_len_q.size(); fd0 = fd_cnt;
    i_base_cnt = 8'd2; i_blank_cnt = 8'(blank_c); i_enable = 1'b1;
    n = 0;
    while (st_addr_q.size() < s0 + 10 * PLANES + 1 && n < 20000) begin
      tick(1);
      n++;
    end
    check("c_reached_row10", 32'(st_addr_q.size() >= s0 + 10 * PLANES + 1), 32'd1);
    i_enable = 1'b0;
    i_base_cnt = 8'd4;
    wait_frame(fd0, 40000);
    tick(5);
    verify_frame(s0, o0, 2, (blank_c == 0) ? 1 : blank_c, fd0, "c");
    check("c_end_busy", 32'(o_busy), 32'd0);
    check("c_end_oe_n", 32'(o_oe_n), 32'd1);
    check("c_row_change_while_lit", 32'(viol), 32'd0);

    // Ready held low in ISSUE, then reset during SHOW
    tx_hold = 1'b1;
    s0 = st_addr_q.size();
    i_base_cnt = 8'd3; i_blank_cnt = 8'd2; i_enable = 1'b1;
    tick(50);
    check("hold_busy", 32'(o_busy), 32'd1);
    check("hold_no_start", 32'(st_addr_q.size() - s0), 32'd0);
    tx_hold = 1'b0;
    i_enable = 1'b0;
    n = 0;
    while (st_addr_q.size() == s0 && n < 20) begin
      tick(1);
      n++;
    end
    check("release_start", 32'(st_addr_q.size() - s0), 32'd1);
    n = 0;
    while (o_oe_n !== 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    check("reached_show", 32'(o_oe_n), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_oe_immediate", 32'(o_oe_n), 32'd1);
    tick(1);
    check("rst_oe_n", 32'(o_oe_n), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_row_addr", 32'(o_row_addr), 32'd0);
    check("rst_init_addr", 32'(o_tx_init_addr), 32'd0);
    check("rst_pix_bit", 32'(o_tx_pix_bit), 32'd0);
    rst = 1'b0;
    s0 = st_addr_q.size();
    tick(15);
    check("post_rst_no_start", 32'(st_addr_q.size() - s0), 32'd0);
    check("post_rst_idle", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Scan and bit-plane sequencer that sits directly upstream of hub75_color_tx.
- For each display row and each colour bit plane, it commands one row shift through the tx handshake (start, init address, pixel bit) and waits for the shift and latch to finish.
- It then drives the panel row address and an active-low output enable for a binary-weighted on-time.
- Together these implement binary code modulation (BCM) brightness across a full frame.

Parameters:
- hpixel_p, 64, display width in pixels.
- vpixel_p, 64, display height in pixels.
- bpp_p, 8, bits per colour channel.
- segments_p, 2, number of display segments driven in parallel.
- Derived (localparam): rows_p = vpixel_p/segments_p; row_width_p = $clog2(rows_p); addr_width_p = $clog2(hpixel_p*vpixel_p); pix_bit_width_p = $clog2(bpp_p).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_enable  in  1  run request; sampled only in IDLE and at frame end.
- i_base_cnt  in  8  on-time of bit plane 0 in clk cycles; 0 is treated as 1.
- i_blank_cnt  in  8  dead time with OE off after each plane; 0 is treated as 1.
- i_tx_ready  in  1  o_ready from hub75_color_tx.
- o_tx_start  out  1  single-cycle start pulse to tx.
- o_tx_init_addr  out  addr_width_p  first pixel address of the row.
- o_tx_pix_bit  out  pix_bit_width_p  bit plane to shift.
- o_row_addr  out  row_width_p  panel row select (A..E lines).
- o_oe_n  out  1  panel output enable, active-low.
- o_frame_done  out  1  one-cycle pulse after the last plane of the last row.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: o_oe_n=1; all other outputs 0; FSM in IDLE; row=0; bit=0.
- Reset asserted mid-operation: the same values take effect at the next edge, with o_oe_n=1 immediately. No handshake with tx is completed.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, SHOW, BLANK.
- IDLE:
  - o_oe_n=1.
  - If i_enable=1: sample i_base_cnt and i_blank_cnt into internal registers, set row=0 and bit=0, go to ISSUE.
  - Configuration is fixed for the whole frame.
- ISSUE:
  - o_tx_init_addr = row*hpixel_p and o_tx_pix_bit = bit are registered on entry and held stable until the next ISSUE.
  - On a cycle with i_tx_ready=1: o_tx_start=1 for exactly that cycle, go to WAIT_BUSY.
  - Otherwise wait, with o_tx_start=0.
- WAIT_BUSY: on i_tx_ready=0, go to WAIT_DONE.
- WAIT_DONE:
  - On i_tx_ready=1 (shift and latch complete): o_row_addr <= row, load on_cnt = base << bit, o_oe_n <= 0, go to SHOW.
  - o_row_addr changes only while o_oe_n=1.
- SHOW:
  - o_oe_n stays low for exactly base<<bit cycles (on_cnt is 8+bpp_p bits wide, so there is no overflow).
  - Then o_oe_n <= 1, load the blank counter, go to BLANK.
- BLANK: o_oe_n=1 for exactly max(blank,1) cycles, then:
  - if bit < bpp_p-1: bit++, go to ISSUE;
  - else if row < rows_p-1: bit=0, row++, go to ISSUE;
  - else (frame end): o_frame_done=1 for one cycle; if i_enable=1, resample config, row=0, bit=0, go to ISSUE; else go to IDLE.
- Deasserting i_enable mid-frame has no effect until frame end; the frame always completes.
- o_oe_n is never low in IDLE, ISSUE, WAIT_BUSY, WAIT_DONE or BLANK.
- Sequence order: bit planes go LSB first within each row; rows go 0..rows_p-1.
- With defaults, one frame contains 32*8 = 256 tx_start pulses.

Test Plan:
- Reset, i_enable=0 for 20 cycles -> o_oe_n=1, o_busy=0, no o_tx_start pulses, all other outputs 0.
- i_enable=1, base=2, blank=1, tx model with ready dropping one cycle after start and returning 10 cycles later -> first start has init_addr=0 and pix_bit=0; o_oe_n low exactly 2 cycles for bit 0 and exactly 256 cycles for bit 7.
- Full frame, defaults -> 256 start pulses; row 5 issued with init_addr=320; o_row_addr steps 0..31; exactly one o_frame_done pulse; o_row_addr never changes while o_oe_n=0.
- base=0, blank=0 -> behaves as 1: bit 0 on-time is 1 cycle and each blank period is 1 cycle.
- Drop i_enable during row 10, and separately change i_base_cnt from 2 to 4 mid-frame -> frame completes using base=2, o_frame_done pulses, FSM returns to IDLE with o_oe_n=1.
- Hold i_tx_ready=0 for 50 cycles while in ISSUE, then assert rst in SHOW -> no start pulse until ready=1; after reset o_oe_n=1 and row=0 at the next edge.
